// File: rtl/n101_icache_ram_ctrl_pkg.sv
// rtl/n101_icache_ram_ctrl_pkg.sv - shared state encoding and default icache RAM geometry
package n101_icache_ram_ctrl_pkg;

    // Default geometry of the I-cache tag/data RAM wrappers.
    localparam int ICACHE_WAYS        = 2;
    localparam int ICACHE_TAG_RAM_AW  = 6;
    localparam int ICACHE_TAG_RAM_DW  = 22;
    localparam int ICACHE_DATA_RAM_AW = 8;
    localparam int ICACHE_DATA_RAM_DW = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_INV  = 2'd2
    } ram_ctrl_state_e;

    // One-hot way select. A single-way cache always selects way 0,
    // whatever the requester put on its way bit.
    function automatic logic [1:0] way_sel(input int ways, input logic way);
        logic [1:0] oh;
        oh = 2'b01;
        if (ways > 1 && way) begin
            oh = 2'b10;
        end
        return oh;
    endfunction

endpackage

// File: rtl/n101_icache_ram_ctrl_if.sv
// rtl/n101_icache_ram_ctrl_if.sv - IFU lookup, refill and cache RAM bus bundle
// master: IFU/refill requesters and RAM wrappers; slave: the RAM controller.
interface n101_icache_ram_ctrl_if #(
    parameter int WAYS    = 2,
    parameter int TAG_AW  = 6,
    parameter int TAG_DW  = 22,
    parameter int DATA_AW = 8,
    parameter int DATA_DW = 32
);
    logic                 rd_req;
    logic                 rd_rdy;
    logic [TAG_AW-1:0]    rd_tindex;
    logic [DATA_AW-1:0]   rd_dindex;
    logic                 rd_rsp_vld;

    logic                 rf_req;
    logic                 rf_rdy;
    logic                 rf_way;
    logic                 rf_tag_we;
    logic [TAG_AW-1:0]    rf_tindex;
    logic [TAG_DW-1:0]    rf_tag;
    logic [DATA_AW-1:0]   rf_dindex;
    logic [DATA_DW-1:0]   rf_data;

    logic [WAYS-1:0]      tag_cs;
    logic                 tag_we;
    logic [TAG_AW-1:0]    tag_addr;
    logic [TAG_DW-1:0]    tag_wdata;
    logic [WAYS-1:0]      data_cs;
    logic                 data_we;
    logic [DATA_AW-1:0]   data_addr;
    logic [DATA_DW-1:0]   data_wdata;

    modport master (
        output rd_req, rd_tindex, rd_dindex,
        output rf_req, rf_way, rf_tag_we, rf_tindex, rf_tag, rf_dindex, rf_data,
        input  rd_rdy, rd_rsp_vld, rf_rdy,
        input  tag_cs, tag_we, tag_addr, tag_wdata,
        input  data_cs, data_we, data_addr, data_wdata
    );

    modport slave (
        input  rd_req, rd_tindex, rd_dindex,
        input  rf_req, rf_way, rf_tag_we, rf_tindex, rf_tag, rf_dindex, rf_data,
        output rd_rdy, rd_rsp_vld, rf_rdy,
        output tag_cs, tag_we, tag_addr, tag_wdata,
        output data_cs, data_we, data_addr, data_wdata
    );

endinterface

// File: rtl/n101_icache_ram_walker.sv
// rtl/n101_icache_ram_walker.sv - tag index walk counter shared by post-reset clear and invalidate
// en: walk active; cnt: current tag index; wrap: last index of the walk (walk done this cycle).
module n101_icache_ram_walker #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [AW-1:0] cnt,
    output logic          wrap
);

    assign wrap = en && (cnt == {AW{1'b1}});

    // Natural overflow returns cnt to 0, so the next walk starts at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + AW'(1);
        end
    end

endmodule

// File: rtl/n101_icache_ram_ctrl.sv
// rtl/n101_icache_ram_ctrl.sv - I-cache tag/data SRAM sequencer and access arbiter
// clk/rst_n: clock, async active-low reset; init_done: post-reset tag clear finished;
// inv_req/inv_ack: invalidate-all level request and completion pulse;
// bus: IFU lookup and refill handshakes plus per-way tag/data RAM controls.
module n101_icache_ram_ctrl
    import n101_icache_ram_ctrl_pkg::*;
#(
    parameter int WAYS    = ICACHE_WAYS,
    parameter int TAG_AW  = ICACHE_TAG_RAM_AW,
    parameter int TAG_DW  = ICACHE_TAG_RAM_DW,
    parameter int DATA_AW = ICACHE_DATA_RAM_AW,
    parameter int DATA_DW = ICACHE_DATA_RAM_DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       init_done,
    input  logic                       inv_req,
    output logic                       inv_ack,
    n101_icache_ram_ctrl_if.slave      bus
);

    ram_ctrl_state_e   state_q;
    ram_ctrl_state_e   state_d;
    logic [TAG_AW-1:0] cnt;
    logic              wrap;
    logic              walk_en;
    logic              rd_grant;
    logic [1:0]        way_oh2;
    logic [WAYS-1:0]   way_oh;

    assign walk_en = (state_q != ST_RUN);
    assign way_oh2 = way_sel(WAYS, bus.rf_way);
    assign way_oh  = way_oh2[WAYS-1:0];

    n101_icache_ram_walker #(.AW(TAG_AW)) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (walk_en),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_comb begin
        state_d        = state_q;
        rd_grant       = 1'b0;
        bus.rd_rdy     = 1'b0;
        bus.rf_rdy     = 1'b0;
        bus.tag_cs     = '0;
        bus.tag_we     = 1'b0;
        bus.tag_addr   = '0;
        bus.tag_wdata  = '0;
        bus.data_cs    = '0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;

        case (state_q)
            ST_INIT, ST_INV: begin
                // Gated by rst_n so the RAMs see no write strobes while reset is held.
                if (rst_n) begin
                    bus.tag_cs   = '1;
                    bus.tag_we   = 1'b1;
                    bus.tag_addr = cnt;
                end
                if (wrap) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (inv_req) begin
                    state_d = ST_INV;
                end else if (bus.rf_req) begin
                    bus.rf_rdy     = 1'b1;
                    bus.data_cs    = way_oh;
                    bus.data_we    = 1'b1;
                    bus.data_addr  = bus.rf_dindex;
                    bus.data_wdata = bus.rf_data;
                    if (bus.rf_tag_we) begin
                        bus.tag_cs    = way_oh;
                        bus.tag_we    = 1'b1;
                        bus.tag_addr  = bus.rf_tindex;
                        bus.tag_wdata = bus.rf_tag;
                    end
                end else if (bus.rd_req) begin
                    rd_grant      = 1'b1;
                    bus.rd_rdy    = 1'b1;
                    bus.tag_cs    = '1;
                    bus.tag_addr  = bus.rd_tindex;
                    bus.data_cs   = '1;
                    bus.data_addr = bus.rd_dindex;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            init_done      <= 1'b0;
            inv_ack        <= 1'b0;
            bus.rd_rsp_vld <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_done      <= init_done | ((state_q == ST_INIT) && wrap);
            inv_ack        <= (state_q == ST_INV) && wrap;
            bus.rd_rsp_vld <= rd_grant;
        end
    end

endmodule
